// File: rtl/pipelined_ripple_adder.sv
// Pipelined add/subtract with the carry chain cut into STAGES ripple segments.
// Operands are skewed into their segment, sums deskewed so every bit leaves together.
module pipelined_ripple_adder #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             overflow
);

   localparam int unsigned SEG  = WIDTH / STAGES;
   localparam int unsigned LAST = STAGES - 1;

   // Per-stage registers: operand skew, partial sum (deskew), segment carry, valid
   logic [WIDTH-1:0] r_a   [STAGES];
   logic [WIDTH-1:0] r_b   [STAGES];
   logic [WIDTH-1:0] r_sum [STAGES];
   logic             r_c   [STAGES];
   logic             r_v   [STAGES];
   logic             r_ovf;

   // Stage inputs and next-state values
   logic [WIDTH-1:0] w_sa   [STAGES];
   logic [WIDTH-1:0] w_sb   [STAGES];
   logic [WIDTH-1:0] w_ssum [STAGES];
   logic             w_sc   [STAGES];
   logic             w_sv   [STAGES];
   logic [WIDTH-1:0] w_nsum [STAGES];
   logic             w_nc   [STAGES];
   logic [SEG:0]     w_seg  [STAGES];

   logic [WIDTH-1:0] w_bx;
   logic             w_c0;
   logic             w_adv;
   logic             w_ovf;

   assign w_bx  = sub ? ~B : B;
   assign w_c0  = sub ? ~Cin : Cin;
   assign w_adv = out_ready | ~r_v[LAST];

   // Route each stage's inputs and ripple its own segment
   always_comb begin
      w_sa[0]   = A;
      w_sb[0]   = w_bx;
      w_sc[0]   = w_c0;
      w_sv[0]   = in_valid;
      w_ssum[0] = '0;
      for (int k = 1; k < int'(STAGES); k++) begin
         w_sa[k]   = r_a[k-1];
         w_sb[k]   = r_b[k-1];
         w_sc[k]   = r_c[k-1];
         w_sv[k]   = r_v[k-1];
         w_ssum[k] = r_sum[k-1];
      end
      for (int k = 0; k < int'(STAGES); k++) begin
         w_seg[k]  = (SEG+1)'(w_sa[k][k*SEG +: SEG])
                   + (SEG+1)'(w_sb[k][k*SEG +: SEG])
                   + (SEG+1)'(w_sc[k]);
         w_nsum[k] = w_ssum[k];
         w_nsum[k][k*SEG +: SEG] = w_seg[k][SEG-1:0];
         w_nc[k]   = w_seg[k][SEG];
      end
      // MSB carry-in recovered from a^b^sum at the top bit
      w_ovf = w_sa[LAST][WIDTH-1] ^ w_sb[LAST][WIDTH-1]
            ^ w_nsum[LAST][WIDTH-1] ^ w_nc[LAST];
   end

   // Whole pipeline shifts together or holds together
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < int'(STAGES); k++) begin
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_sum[k] <= '0;
            r_c[k]   <= 1'b0;
            r_v[k]   <= 1'b0;
         end
         r_ovf <= 1'b0;
      end else if (w_adv) begin
         for (int k = 0; k < int'(STAGES); k++) begin
            r_a[k]   <= w_sa[k];
            r_b[k]   <= w_sb[k];
            r_sum[k] <= w_nsum[k];
            r_c[k]   <= w_nc[k];
            r_v[k]   <= w_sv[k];
         end
         r_ovf <= w_ovf;
      end
   end

   assign in_ready  = w_adv;
   assign out_valid = r_v[LAST];
   assign Sum       = r_sum[LAST];
   assign Cout      = r_c[LAST];
   assign overflow  = r_ovf;

endmodule

// File: doc/pipelined_ripple_adder.md
# pipelined_ripple_adder

Parametrised, pipelined successor to the team's 4-bit ripple carry adder. Adds or subtracts two WIDTH-bit operands with carry/borrow-in. The carry chain is split into STAGES equal ripple segments separated by registers, so one result is accepted per clock. It sits between operand producers and consumers that use a valid/ready handshake, and reports carry-out and signed overflow alongside the sum.

## Interface
- WIDTH, default 8: operand and sum width. Must be ≥ 2 and divisible by STAGES.
- STAGES, default 4: number of pipeline segments, ≥ 1. Segment width SEG = WIDTH/STAGES.
- clk  in  1  rising-edge clock; the block has one clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands on A/B/Cin/sub are valid this cycle.
- in_ready  out  1  block accepts operands this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Cin  in  1  carry-in when sub=0; borrow-in when sub=1.
- sub  in  1  0: A+B+Cin; 1: A−B−Cin.
- out_valid  out  1  result fields are valid.
- out_ready  in  1  consumer accepts the result.
- Sum  out  WIDTH  result modulo 2^WIDTH.
- Cout  out  1  raw carry out of the MSB. In subtract mode, 1 means no borrow.
- overflow  out  1  signed two's-complement overflow.

## Operation
- **Effective operands:**
  - Bx = sub ? ~B : B.
  - c0 = sub ? ~Cin : Cin.
  - Result = A + Bx + c0 over WIDTH+1 bits: {Cout, Sum}.
- **Segments:** segment k (0..STAGES−1) ripples bits [k·SEG +: SEG].
  - Segment k's carry-in is the registered carry-out of segment k−1; segment 0 uses c0.
- **Operand skew:** segment k's bits of A and Bx are delayed k register stages so they meet their carry.
- **Result deskew:** segment k's sum bits are delayed STAGES−1−k further stages so all Sum bits leave together.
- **Overflow:** MSB carry-in XOR MSB carry-out, computed in the last segment.
- **Stage state:** each stage holds a valid bit. Bubbles (in_valid=0 on an accepted cycle) propagate as valid=0.
- **Advance rule:** advance = out_ready | ~out_valid.
  - When advance=1, every stage shifts one position and the input stage captures in_valid plus the operands.
  - When advance=0, all registers hold.
- in_ready = advance (combinational from out_ready and out_valid; no combinational path from in_valid).
- An accepted transfer is in_valid & in_ready. Data presented while in_ready=0 is ignored and must be held by the producer.
- **Reset:** asynchronous. All valid bits, skew/deskew registers and outputs clear immediately.
  - Sum=0, Cout=0, overflow=0, out_valid=0; in_ready=1 after reset.
- Reset mid-operation discards every in-flight result; no partial result is ever presented.
- **STAGES=1:** single registered full-width ripple adder with latency 1.

## Timing
- **Latency:** an operand accepted at edge N appears with out_valid=1 after edge N+STAGES−1. It is registered on the output stage and visible in the cycle following that edge, i.e. STAGES cycles from acceptance to visibility.
- **Throughput:** one result per cycle while out_ready=1.
- **Stall:** while out_valid=1 and out_ready=0, outputs are stable and in_ready=0.
  - Up to STAGES results are held in flight without loss.
- **Simultaneous events:**
  - out_ready rising in the same cycle as a new in_valid: the output is consumed and the input accepted on the same edge.
  - With the pipeline empty, out_valid=0 and in_ready=1 regardless of out_ready.
- **Arithmetic wrap:** Sum is modulo 2^WIDTH; the carry goes to Cout only.

## Test plan
Cases 1–3 use WIDTH=8, STAGES=4; results appear 4 cycles after acceptance.
- **Add wrap:** A=0xFF, B=0x01, Cin=0, sub=0 -> Sum=0x00, Cout=1, overflow=0.
- **Signed overflow:** A=0x7F, B=0x01, Cin=0, sub=0 -> Sum=0x80, Cout=0, overflow=1.
- **Subtract with borrow:**
  - A=0x05, B=0x07, Cin=0, sub=1 -> Sum=0xFE, Cout=0, overflow=0.
  - A=0x80, B=0x01, Cin=0, sub=1 -> Sum=0x7F, overflow=1.
- **Back-to-back and backpressure:**
  - Stimulus: 10 random operand sets on consecutive cycles with out_ready=1, then out_ready=0 for 5 cycles, then 1 again.
  - Required: results arrive in order with no gaps, each matching the reference model {Cout,Sum}=A+Bx+c0.
  - Required: in_ready=0 and outputs frozen during the stall; nothing lost or duplicated.
- **Reset mid-operation:**
  - Stimulus: assert reset asynchronously (between edges) with 3 results in flight.
  - Required: out_valid=0 and Sum/Cout/overflow=0 immediately; no stale result after release; a new operand (0x10+0x20) returns 0x30 4 cycles after acceptance.
- **Parameter sweep:**
  - Configurations: WIDTH=16/STAGES=1 (latency 1), WIDTH=16/STAGES=16, and WIDTH=32/STAGES=4.
  - Required: 1000 random add/sub vectors each with random out_ready match the reference model.
